// File: rtl/falafel_mem_responder.sv
// Memory-side responder for the falafel request/response interface: word array,
// fixed-latency valid/data pipeline and a fall-through in-order response queue.
module falafel_mem_responder #(
  parameter int unsigned      DATA_W      = 64,
  parameter int unsigned      DEPTH_WORDS = 1024,
  parameter longint unsigned  BASE_ADDR   = 0,
  parameter int unsigned      LATENCY     = 2,
  parameter int unsigned      RSP_DEPTH   = 4
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              mem_req_val_i,
  output logic              mem_req_rdy_o,
  input  logic              mem_req_is_write_i,
  input  logic [DATA_W-1:0] mem_req_addr_i,
  input  logic [DATA_W-1:0] mem_req_data_i,
  output logic              mem_rsp_val_o,
  input  logic              mem_rsp_rdy_i,
  output logic [DATA_W-1:0] mem_rsp_data_o,
  output logic              err_o,
  output logic [DATA_W-1:0] err_addr_o
);

  localparam int unsigned BYTES = DATA_W / 8;
  localparam int unsigned SHIFT = $clog2(BYTES);
  localparam int unsigned IDX_W = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
  localparam int unsigned CNT_W = $clog2(RSP_DEPTH + 1);
  localparam int unsigned PTR_W = (RSP_DEPTH > 1) ? $clog2(RSP_DEPTH) : 1;
  localparam logic [DATA_W-1:0] BASE       = DATA_W'(BASE_ADDR);
  localparam logic [DATA_W-1:0] ALIGN_MASK = DATA_W'(BYTES - 1);
  localparam logic [DATA_W-1:0] WORDS      = DATA_W'(DEPTH_WORDS);
  localparam logic [CNT_W-1:0]  MAX_OUT    = CNT_W'(RSP_DEPTH);
  localparam logic [PTR_W-1:0]  LAST_PTR   = PTR_W'(RSP_DEPTH - 1);

  logic [DATA_W-1:0] mem_q [DEPTH_WORDS];
  logic [DATA_W-1:0] offset, index, rsp_in_data;
  logic              bad_addr, accept, pop;

  logic [LATENCY-1:0] pipe_val_q;
  logic [DATA_W-1:0]  pipe_data_q [LATENCY];

  logic [DATA_W-1:0] fifo_q [RSP_DEPTH];
  logic [PTR_W-1:0]  rd_ptr_q, wr_ptr_q;
  logic [CNT_W-1:0]  fifo_cnt_q, out_cnt_q;
  logic              fifo_empty, fifo_push, fifo_pop;
  logic              err_q;
  logic [DATA_W-1:0] err_addr_q;

  assign offset   = mem_req_addr_i - BASE;
  assign index    = offset >> SHIFT;
  assign bad_addr = ((offset & ALIGN_MASK) != '0) || (mem_req_addr_i < BASE) || (index >= WORDS);

  assign mem_req_rdy_o = !rst_i && (out_cnt_q < MAX_OUT);
  assign accept        = mem_req_val_i && mem_req_rdy_o;

  always_comb begin
    rsp_in_data = '0;
    if (!bad_addr) begin
      rsp_in_data = mem_req_is_write_i ? mem_req_data_i : mem_q[index[IDX_W-1:0]];
    end
  end

  always_ff @(posedge clk_i) begin
    if (accept && mem_req_is_write_i && !bad_addr) begin
      mem_q[index[IDX_W-1:0]] <= mem_req_data_i;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      pipe_val_q <= '0;
      for (int unsigned i = 0; i < LATENCY; i++) pipe_data_q[i] <= '0;
    end else begin
      pipe_val_q[0]  <= accept;
      pipe_data_q[0] <= accept ? rsp_in_data : '0;
      for (int unsigned i = 1; i < LATENCY; i++) begin
        pipe_val_q[i]  <= pipe_val_q[i-1];
        pipe_data_q[i] <= pipe_data_q[i-1];
      end
    end
  end

  // Queue bypass: an empty queue shows the last pipeline stage directly; the
  // entry is only pushed when the initiator does not take it this cycle.
  assign fifo_empty     = (fifo_cnt_q == '0);
  assign fifo_push      = pipe_val_q[LATENCY-1] && !(fifo_empty && mem_rsp_rdy_i);
  assign fifo_pop       = !fifo_empty && mem_rsp_rdy_i;
  assign mem_rsp_val_o  = !fifo_empty || pipe_val_q[LATENCY-1];
  assign mem_rsp_data_o = fifo_empty ? pipe_data_q[LATENCY-1] : fifo_q[rd_ptr_q];
  assign pop            = mem_rsp_val_o && mem_rsp_rdy_i;

  always_ff @(posedge clk_i) begin
    if (fifo_push) fifo_q[wr_ptr_q] <= pipe_data_q[LATENCY-1];
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      rd_ptr_q   <= '0;
      wr_ptr_q   <= '0;
      fifo_cnt_q <= '0;
      out_cnt_q  <= '0;
      err_q      <= 1'b0;
      err_addr_q <= '0;
    end else begin
      if (fifo_push) wr_ptr_q <= (wr_ptr_q == LAST_PTR) ? '0 : wr_ptr_q + PTR_W'(1);
      if (fifo_pop)  rd_ptr_q <= (rd_ptr_q == LAST_PTR) ? '0 : rd_ptr_q + PTR_W'(1);
      case ({fifo_push, fifo_pop})
        2'b10:   fifo_cnt_q <= fifo_cnt_q + CNT_W'(1);
        2'b01:   fifo_cnt_q <= fifo_cnt_q - CNT_W'(1);
        default: fifo_cnt_q <= fifo_cnt_q;
      endcase
      case ({accept, pop})
        2'b10:   out_cnt_q <= out_cnt_q + CNT_W'(1);
        2'b01:   out_cnt_q <= out_cnt_q - CNT_W'(1);
        default: out_cnt_q <= out_cnt_q;
      endcase
      if (accept && bad_addr) begin
        err_q <= 1'b1;
        if (!err_q) err_addr_q <= mem_req_addr_i;
      end
    end
  end

  assign err_o      = err_q;
  assign err_addr_o = err_addr_q;

endmodule

// File: tb/tb_falafel_mem_responder.sv
// Directed bench for falafel_mem_responder: vector table plus hand-written
// back-to-back, backpressure, reset and LATENCY=1 sequences.
module tb_falafel_mem_responder;

  logic        clk, rst;
  logic        req_val, req_rdy, req_wr, rsp_val, rsp_rdy, err;
  logic [63:0] req_addr, req_data, rsp_data, err_addr;

  logic        val1, rdy1, wr1, rval1, err1;
  logic [63:0] addr1, data1, rdata1, eaddr1;

  int n_vec  = 0;
  int n_miss = 0;

  falafel_mem_responder #(.DATA_W(64), .DEPTH_WORDS(1024), .BASE_ADDR(0),
                          .LATENCY(2), .RSP_DEPTH(4)) u_dut (
    .clk_i(clk), .rst_i(rst),
    .mem_req_val_i(req_val), .mem_req_rdy_o(req_rdy),
    .mem_req_is_write_i(req_wr), .mem_req_addr_i(req_addr), .mem_req_data_i(req_data),
    .mem_rsp_val_o(rsp_val), .mem_rsp_rdy_i(rsp_rdy), .mem_rsp_data_o(rsp_data),
    .err_o(err), .err_addr_o(err_addr)
  );

  falafel_mem_responder #(.DATA_W(64), .DEPTH_WORDS(1024), .BASE_ADDR(0),
                          .LATENCY(1), .RSP_DEPTH(4)) u_l1 (
    .clk_i(clk), .rst_i(rst),
    .mem_req_val_i(val1), .mem_req_rdy_o(rdy1),
    .mem_req_is_write_i(wr1), .mem_req_addr_i(addr1), .mem_req_data_i(data1),
    .mem_rsp_val_o(rval1), .mem_rsp_rdy_i(1'b1), .mem_rsp_data_o(rdata1),
    .err_o(err1), .err_addr_o(eaddr1)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  typedef struct {
    logic        is_write;
    logic [63:0] addr;
    logic [63:0] data;
    logic [63:0] exp_data;
    logic        exp_err;
    logic [63:0] exp_err_addr;
  } vec_t;

  vec_t vecs [14];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_miss++;
      $display("FAIL %s: got %h, want %h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One request with rsp_rdy=1 on the LATENCY=2 instance
  task automatic apply_vec(input int i);
    req_val  = 1'b1;
    req_wr   = vecs[i].is_write;
    req_addr = vecs[i].addr;
    req_data = vecs[i].data;
    rsp_rdy  = 1'b1;
    check($sformatf("v%0d rdy", i), req_rdy, 1);
    tick();
    req_val = 1'b0;
    check($sformatf("v%0d early_val", i), rsp_val, 0);
    tick();
    check($sformatf("v%0d val", i), rsp_val, 1);
    check($sformatf("v%0d data", i), rsp_data, vecs[i].exp_data);
    tick();
    check($sformatf("v%0d err", i), err, vecs[i].exp_err);
    check($sformatf("v%0d err_addr", i), err_addr, vecs[i].exp_err_addr);
  endtask

  logic [63:0] bp_addr [6];
  logic [63:0] bp_exp  [6];
  logic [63:0] l1_exp  [5];

  initial begin
    vecs[0]  = '{1'b1, 64'h40,   64'hDEAD_BEEF, 64'hDEAD_BEEF, 1'b0, 64'h0};
    vecs[1]  = '{1'b0, 64'h40,   64'h0,         64'hDEAD_BEEF, 1'b0, 64'h0};
    vecs[2]  = '{1'b1, 64'h80,   64'h11,        64'h11,        1'b0, 64'h0};
    vecs[3]  = '{1'b0, 64'h80,   64'h0,         64'h11,        1'b0, 64'h0};
    vecs[4]  = '{1'b1, 64'h1FF8, 64'hA5A5,      64'hA5A5,      1'b0, 64'h0};
    vecs[5]  = '{1'b0, 64'h1FF8, 64'h0,         64'hA5A5,      1'b0, 64'h0};
    vecs[6]  = '{1'b1, 64'h0,    64'h123,       64'h123,       1'b0, 64'h0};
    vecs[7]  = '{1'b0, 64'h0,    64'h0,         64'h123,       1'b0, 64'h0};
    vecs[8]  = '{1'b0, 64'h44,   64'h0,         64'h0,         1'b1, 64'h44};
    vecs[9]  = '{1'b1, 64'h2000, 64'hFFFF,      64'h0,         1'b1, 64'h44};
    vecs[10] = '{1'b0, 64'h1FFC, 64'h0,         64'h0,         1'b1, 64'h44};
    vecs[11] = '{1'b0, 64'h0,    64'h0,         64'h123,       1'b1, 64'h44};
    vecs[12] = '{1'b0, 64'h40,   64'h0,         64'hDEAD_BEEF, 1'b0, 64'h0};
    vecs[13] = '{1'b0, 64'h1FF8, 64'h0,         64'hA5A5,      1'b0, 64'h0};

    bp_addr = '{64'h40, 64'h80, 64'h88, 64'h0, 64'h1FF8, 64'h40};
    bp_exp  = '{64'hDEAD_BEEF, 64'h11, 64'h22, 64'h123, 64'hA5A5, 64'hDEAD_BEEF};
    l1_exp  = '{64'h5, 64'h6, 64'h5, 64'h6, 64'h5};

    rst = 1'b1; req_val = 1'b0; req_wr = 1'b0; req_addr = '0; req_data = '0; rsp_rdy = 1'b0;
    val1 = 1'b0; wr1 = 1'b0; addr1 = '0; data1 = '0;
    #2;
    check("rst rdy", req_rdy, 0);
    check("rst val", rsp_val, 0);
    check("rst data", rsp_data, 0);
    check("rst err", err, 0);
    check("rst err_addr", err_addr, 0);
    #10 rst = 1'b0;
    tick();
    check("post-rst rdy", req_rdy, 1);

    for (int i = 0; i < 8; i++) apply_vec(i);

    // Back-to-back write then read of the same word
    rsp_rdy = 1'b1;
    req_val = 1'b1; req_wr = 1'b1; req_addr = 64'h88; req_data = 64'h22;
    tick();
    req_wr = 1'b0; req_data = '0;
    check("b2b T+1 val", rsp_val, 0);
    tick();
    req_val = 1'b0;
    check("b2b wr val", rsp_val, 1);
    check("b2b wr data", rsp_data, 64'h22);
    tick();
    check("b2b rd val", rsp_val, 1);
    check("b2b rd data", rsp_data, 64'h22);
    tick();
    check("b2b idle", rsp_val, 0);

    // Backpressure: six reads offered, four fit
    begin
      int k, pops;
      logic r;
      k = 0; pops = 0;
      rsp_rdy = 1'b0;
      for (int c = 0; c < 6; c++) begin
        req_val = 1'b1; req_addr = bp_addr[k];
        r = req_rdy;
        tick();
        if (r) k++;
      end
      check("bp accepted", 64'(k), 4);
      check("bp rdy low", req_rdy, 0);
      check("bp val", rsp_val, 1);
      check("bp head", rsp_data, bp_exp[0]);
      tick();
      check("bp hold val", rsp_val, 1);
      check("bp hold data", rsp_data, bp_exp[0]);
      rsp_rdy = 1'b1;
      for (int c = 0; c < 12; c++) begin
        logic drove;
        drove = (k < 6);
        req_val = drove;
        if (drove) req_addr = bp_addr[k];
        r = req_rdy;
        if (c == 0) check("bp rdy before pop", r, 0);
        if (c == 1) check("bp rdy after pop", r, 1);
        if (rsp_val) begin
          if (pops < 6) check($sformatf("bp rsp%0d", pops), rsp_data, bp_exp[pops]);
          pops++;
        end
        tick();
        if (drove && r) k++;
      end
      req_val = 1'b0;
      check("bp total accepted", 64'(k), 6);
      check("bp total responses", 64'(pops), 6);
    end

    for (int i = 8; i < 12; i++) apply_vec(i);

    // Reset with three reads outstanding, asserted between clock edges
    rsp_rdy = 1'b0;
    for (int c = 0; c < 3; c++) begin
      req_val = 1'b1; req_wr = 1'b0; req_addr = bp_addr[c];
      check($sformatf("mid rdy%0d", c), req_rdy, 1);
      tick();
    end
    req_val = 1'b0;
    check("mid pending val", rsp_val, 1);
    #3 rst = 1'b1;
    #1;
    check("mid rst val", rsp_val, 0);
    check("mid rst data", rsp_data, 0);
    check("mid rst rdy", req_rdy, 0);
    check("mid rst err", err, 0);
    check("mid rst err_addr", err_addr, 0);
    @(posedge clk);
    #3 rst = 1'b0;
    tick();
    check("mid post rdy", req_rdy, 1);
    rsp_rdy = 1'b1;
    for (int c = 0; c < 5; c++) begin
      check($sformatf("mid stale%0d", c), rsp_val, 0);
      tick();
    end
    apply_vec(12);
    apply_vec(13);

    // LATENCY=1 instance: five requests in consecutive cycles
    for (int i = 0; i < 6; i++) begin
      if (i < 5) begin
        val1  = 1'b1;
        wr1   = (i < 2);
        addr1 = (i % 2 == 0) ? 64'h10 : 64'h18;
        data1 = (i == 0) ? 64'h5 : 64'h6;
        check($sformatf("l1 rdy%0d", i), rdy1, 1);
      end else begin
        val1 = 1'b0;
      end
      if (i == 0) check("l1 idle", rval1, 0);
      else begin
        check($sformatf("l1 val%0d", i - 1), rval1, 1);
        check($sformatf("l1 data%0d", i - 1), rdata1, l1_exp[i-1]);
      end
      tick();
    end
    check("l1 drained", rval1, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule

// File: doc/falafel_mem_responder.md
Name: falafel_mem_responder

Overview:
Memory-side responder for the falafel allocator's memory request/response interface: accepts read and write requests from the core's LSU and returns one in-order response per request. Backed by an internal word array with configurable fixed latency and a bounded response queue. Used as the simulation and FPGA memory behind falafel_core, and as the golden end of that protocol for verification.

Parameters:
DATA_W, 64, word width in bits; byte address granularity; word = DATA_W/8 bytes
DEPTH_WORDS, 1024, number of words in the backing array
BASE_ADDR, 0, byte address mapped to word 0
LATENCY, 2, cycles from request accept to earliest response valid; must be >= 1
RSP_DEPTH, 4, maximum outstanding requests (pipeline + queue); must be >= LATENCY

Ports:
clk_i  in  1  clock
rst_i  in  1  reset; asynchronous, active-high
mem_req_val_i  in  1  request valid
mem_req_rdy_o  out  1  responder can accept a request
mem_req_is_write_i  in  1  1 = write, 0 = read
mem_req_addr_i  in  DATA_W  byte address
mem_req_data_i  in  DATA_W  write data
mem_rsp_val_o  out  1  response valid
mem_rsp_rdy_i  in  1  initiator ready for the response
mem_rsp_data_o  out  DATA_W  read data, or echoed write data
err_o  out  1  sticky: a bad address has been seen
err_addr_o  out  DATA_W  address of the first bad request

Behaviour:
- Reset: this is the only decided interface item. One clock, clk_i; reset rst_i is asynchronous and active-high. While rst_i is asserted: mem_req_rdy_o=0, mem_rsp_val_o=0, mem_rsp_data_o=0, err_o=0, err_addr_o=0, outstanding count=0, pipeline and queue empty. Array contents are not reset.
- Accept: a request is accepted in a cycle when mem_req_val_i && mem_req_rdy_o are both high.
- mem_req_rdy_o = (outstanding_q < RSP_DEPTH). It is driven from the registered count only, with no combinational path from mem_rsp_rdy_i.
- Outstanding count:
  - +1 on accept, -1 on pop (mem_rsp_val_o && mem_rsp_rdy_i).
  - On a simultaneous accept and pop, the count is unchanged.
  - Range is 0..RSP_DEPTH; the response queue can never overflow.
- Address decode:
  - offset = addr - BASE_ADDR; index = offset >> log2(DATA_W/8).
  - Bad address: offset is not word-aligned, or addr < BASE_ADDR, or index >= DEPTH_WORDS.
- Write (good address): the array is updated at the accept clock edge. Response data = mem_req_data_i.
- Read (good address): data is sampled from the array in the accept cycle. It therefore reflects all previously accepted writes, including one accepted in the prior cycle.
- Bad address:
  - No array access; response data = 0; a response is still returned.
  - err_o is set (sticky until reset).
  - err_addr_o captures the address only if err_o was 0.
- Timing:
  - The accepted entry travels a LATENCY-stage valid/data shift pipeline, then enters a fall-through FIFO of RSP_DEPTH entries.
  - A request accepted at cycle T raises mem_rsp_val_o at cycle T+LATENCY if the queue is empty.
  - Otherwise it raises after all older responses have popped.
- Ordering: responses are strictly in acceptance order.
- Response hold: mem_rsp_val_o and mem_rsp_data_o stay stable while mem_rsp_val_o && !mem_rsp_rdy_i.
- Throughput: with mem_rsp_rdy_i held at 1, one request is accepted and one response returned per cycle.
- Reset mid-operation: all in-flight requests and queued responses are dropped. Writes already accepted remain in the array.
- Simultaneous push and pop at a full queue: both happen and the occupancy is unchanged.

Test Plan:
- Write 0xDEAD_BEEF to 0x40, then read 0x40 (BASE_ADDR=0, LATENCY=2) -> write response data 0xDEAD_BEEF at T+2; read response 0xDEAD_BEEF at T'+2; err_o=0.
- Back-to-back: write 0x11 to 0x80 at cycle T, read 0x80 at T+1, mem_rsp_rdy_i=1 -> responses at T+2 and T+3, read returns 0x11.
- Backpressure: mem_rsp_rdy_i=0, issue 6 reads (RSP_DEPTH=4) -> exactly 4 accepted and mem_req_rdy_o=0. Raise mem_rsp_rdy_i -> 4 responses in order; mem_req_rdy_o returns to 1 the cycle after the first pop; remaining 2 accepted.
- Bad addresses: read 0x44 (misaligned), then write to 0x2000 (index 1024 >= DEPTH_WORDS) -> both respond with data 0; err_o=1; err_addr_o=0x44; array unchanged.
- Reset mid-flight: 3 reads outstanding, pulse rst_i asynchronously between edges -> mem_rsp_val_o=0 immediately; count 0; no stale responses after release; earlier write data still readable.
- LATENCY=1 build: read accepted at T -> mem_rsp_val_o at T+1; sustained one-per-cycle with no bubbles.
